// File: rtl/slv_guard_pkg.sv
// Shared types and constants for the slv_guard recovery sequencer.
package slv_guard_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISOLATE = 3'd1,
        RESET   = 3'd2,
        RELEASE = 3'd3,
        REJOIN  = 3'd4,
        FATAL   = 3'd5
    } rst_ctrl_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slv_guard_timer.sv
// Up-counter with synchronous clear, enable and a compare-to-limit terminal count.
module slv_guard_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] limit_i,
    output logic             tc_c
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign tc_c = (cnt_q == limit_i);

endmodule

// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer: isolates, resets, clears and rejoins the protected subordinate
// on a guard reset request, with retry escalation and a sticky host interrupt.
module slv_guard_rst_ctrl
    import slv_guard_pkg::*;
#(
    parameter int unsigned RstCycles     = 16,
    parameter int unsigned IsoTimeout    = 256,
    parameter int unsigned HoldOffCycles = 8,
    parameter int unsigned QuietCycles   = 1024,
    parameter int unsigned MaxRetries    = 3,
    parameter int unsigned CntWidth      = CNT_WIDTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rst_req_i,
    input  logic                irq_i,
    input  logic                isolated_i,
    input  logic                irq_clr_i,
    output logic                isolate_o,
    output logic                slv_rst_no,
    output logic                guard_clr_o,
    output logic                irq_o,
    output logic                busy_o,
    output logic                fatal_o,
    output logic [CntWidth-1:0] rst_cnt_o
);

    localparam int unsigned MaxCycles  = max_u(max_u(RstCycles, IsoTimeout),
                                               max_u(HoldOffCycles, QuietCycles));
    localparam int unsigned TmrWidth   = $clog2(MaxCycles) + 1;
    localparam int unsigned RetryWidth = $clog2(MaxRetries + 2);

    rst_ctrl_state_e         state_q, state_d;
    logic [TmrWidth-1:0]     tmr_limit;
    logic                    tmr_clr, tmr_en, tmr_tc;
    logic                    quiet_en, quiet_tc;
    logic [RetryWidth-1:0]   retry_q;
    logic                    iso_to, rejoin_done, retry_clr;
    logic                    isolate_d, slv_rst_d, guard_clr_d, busy_d, fatal_d, irq_set;

    // Next state plus the values every registered output takes next cycle.
    always_comb begin
        state_d     = state_q;
        iso_to      = 1'b0;
        tmr_limit   = '0;
        rejoin_done = 1'b0;
        isolate_d   = 1'b0;
        slv_rst_d   = 1'b1;
        guard_clr_d = 1'b0;
        busy_d      = 1'b0;
        fatal_d     = 1'b0;
        irq_set     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rst_req_i) begin
                    state_d = (retry_q == RetryWidth'(MaxRetries)) ? FATAL : ISOLATE;
                end
            end
            ISOLATE: begin
                tmr_limit = TmrWidth'(IsoTimeout - 1);
                if (isolated_i) begin
                    state_d = RESET;
                end else if (tmr_tc) begin
                    state_d = RESET;
                    iso_to  = 1'b1;
                end
            end
            RESET: begin
                tmr_limit = TmrWidth'(RstCycles - 1);
                if (tmr_tc) state_d = RELEASE;
            end
            RELEASE: begin
                tmr_limit = TmrWidth'(HoldOffCycles - 1);
                if (tmr_tc) state_d = REJOIN;
            end
            REJOIN: begin
                if (!isolated_i) state_d = IDLE;
            end
            FATAL: state_d = FATAL;
            default: state_d = IDLE;
        endcase

        rejoin_done = (state_q == REJOIN) && (state_d == IDLE);
        isolate_d   = state_d inside {ISOLATE, RESET, RELEASE, FATAL};
        slv_rst_d   = !(state_d inside {RESET, FATAL});
        guard_clr_d = (state_q == RELEASE) && (state_d == REJOIN);
        busy_d      = (state_d != IDLE);
        fatal_d     = (state_d == FATAL);
        irq_set     = irq_i || iso_to || fatal_d;
    end

    // One phase timer shared by ISOLATE/RESET/RELEASE; restarts on every state change.
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = state_q inside {ISOLATE, RESET, RELEASE};

    slv_guard_timer #(.Width(TmrWidth)) u_phase_tmr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .tc_c    (tmr_tc)
    );

    // Quiet timer parks at its limit so the retry clear holds while IDLE continues.
    assign quiet_en  = (state_q == IDLE) && !quiet_tc;
    assign retry_clr = (state_q == IDLE) && quiet_tc;

    slv_guard_timer #(.Width(TmrWidth)) u_quiet_tmr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (rejoin_done),
        .en_i    (quiet_en),
        .limit_i (TmrWidth'(QuietCycles - 1)),
        .tc_c    (quiet_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            isolate_o   <= 1'b0;
            slv_rst_no  <= 1'b1;
            guard_clr_o <= 1'b0;
            irq_o       <= 1'b0;
            busy_o      <= 1'b0;
            fatal_o     <= 1'b0;
            rst_cnt_o   <= '0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            isolate_o   <= isolate_d;
            slv_rst_no  <= slv_rst_d;
            guard_clr_o <= guard_clr_d;
            busy_o      <= busy_d;
            fatal_o     <= fatal_d;

            if (irq_set) begin
                irq_o <= 1'b1;
            end else if (irq_clr_i) begin
                irq_o <= 1'b0;
            end

            if (rejoin_done && (rst_cnt_o != '1)) begin
                rst_cnt_o <= rst_cnt_o + CntWidth'(1);
            end

            if (rejoin_done) begin
                if (retry_q != RetryWidth'(MaxRetries)) retry_q <= retry_q + RetryWidth'(1);
            end else if (retry_clr) begin
                retry_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Self-checking bench for slv_guard_rst_ctrl with a delayed isolate-stage model.
module tb_slv_guard_rst_ctrl;

    localparam int RST_CYCLES  = 16;
    localparam int ISO_TIMEOUT = 256;
    localparam int HOLD_OFF    = 8;
    localparam int QUIET       = 1024;
    localparam int MAX_RETRIES = 3;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic rst_req_i = 1'b0;
    logic irq_i = 1'b0;
    logic irq_clr_i = 1'b0;
    logic isolated_i;
    logic isolate_o, slv_rst_no, guard_clr_o, irq_o, busy_o, fatal_o;
    logic [CNT_W-1:0] rst_cnt_o;

    always #5 clk = ~clk;

    slv_guard_rst_ctrl #(
        .RstCycles     (RST_CYCLES),
        .IsoTimeout    (ISO_TIMEOUT),
        .HoldOffCycles (HOLD_OFF),
        .QuietCycles   (QUIET),
        .MaxRetries    (MAX_RETRIES),
        .CntWidth      (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rst_req_i   (rst_req_i),
        .irq_i       (irq_i),
        .isolated_i  (isolated_i),
        .irq_clr_i   (irq_clr_i),
        .isolate_o   (isolate_o),
        .slv_rst_no  (slv_rst_no),
        .guard_clr_o (guard_clr_o),
        .irq_o       (irq_o),
        .busy_o      (busy_o),
        .fatal_o     (fatal_o),
        .rst_cnt_o   (rst_cnt_o)
    );

    // Isolate stage: acknowledges 3 cycles after isolate_o rises, drops 2 cycles after it falls.
    logic       iso_en = 1'b1;
    logic [2:0] iso_hist = '0;
    always @(posedge clk) iso_hist <= {iso_hist[1:0], isolate_o};
    assign isolated_i = iso_en & iso_hist[1] & iso_hist[2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cnt;
        bit irq;
        bit fatal;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt   = 0;
    int   m_retry = 0;

    // Reference model of one request: recovery or lock-out.
    task automatic model_request(input bit exp_irq);
        exp_t e;
        if (m_retry == MAX_RETRIES) begin
            e.cnt = m_cnt; e.irq = 1'b1; e.fatal = 1'b1;
        end else begin
            m_cnt++; m_retry++;
            e.cnt = m_cnt; e.irq = exp_irq; e.fatal = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Idle gap of w cycles between return to IDLE and the next sampled request.
    task automatic wait_idle(input int w);
        repeat (w - 1) @(negedge clk);
        if (w >= QUIET) m_retry = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; rst_req_i = 1'b0; irq_i = 1'b0; irq_clr_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        m_cnt = 0; m_retry = 0;
        repeat (4) @(negedge clk);
    endtask

    // Issue one request and time the sequence in cycles relative to the request.
    task automatic run_seq(input bit hold, output int t_iso, output int t_fall, output int t_rise,
                           output int n_low, output int t_clr, output int n_clr,
                           output int t_idle, output bit to);
        t_iso = -1; t_fall = -1; t_rise = -1; n_low = 0; t_clr = -1; n_clr = 0; t_idle = -1; to = 1'b1;
        @(negedge clk);
        rst_req_i = 1'b1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (!hold) rst_req_i = 1'b0;
            if (isolate_o && t_iso < 0) t_iso = i;
            if (!slv_rst_no) begin
                if (t_fall < 0) t_fall = i;
                n_low++;
            end else if (t_fall >= 0 && t_rise < 0) begin
                t_rise = i;
            end
            if (guard_clr_o) begin
                n_clr++;
                if (t_clr < 0) t_clr = i;
            end
            if (!busy_o) begin
                t_idle = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (isolate_o !== 1'b0) begin n_fail++; $display("FAIL reset_isolate: got %b expected 0", isolate_o); end
        n_tests++; if (slv_rst_no !== 1'b1) begin n_fail++; $display("FAIL reset_slv_rst_n: got %b expected 1", slv_rst_no); end
        n_tests++; if (guard_clr_o !== 1'b0) begin n_fail++; $display("FAIL reset_guard_clr: got %b expected 0", guard_clr_o); end
        n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_tests++; if (fatal_o !== 1'b0) begin n_fail++; $display("FAIL reset_fatal: got %b expected 0", fatal_o); end
        n_tests++; if (rst_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", rst_cnt_o); end
    endtask

    task automatic test_nominal();
        int t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle;
        bit to;
        exp_t e;
        model_request(1'b0);
        run_seq(1'b0, t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL nom_done: timed out"); end
        n_tests++; if (t_iso !== 1) begin n_fail++; $display("FAIL nom_iso_lat: got %0d expected 1", t_iso); end
        // ISOLATE sees the stage acknowledge 3 cycles after isolate_o, RESET one edge later.
        n_tests++; if (t_fall !== 5) begin n_fail++; $display("FAIL nom_rst_fall: got %0d expected 5", t_fall); end
        n_tests++; if (n_low !== RST_CYCLES) begin n_fail++; $display("FAIL nom_rst_len: got %0d expected %0d", n_low, RST_CYCLES); end
        n_tests++; if (t_clr - t_rise !== HOLD_OFF) begin n_fail++; $display("FAIL nom_holdoff: got %0d expected %0d", t_clr - t_rise, HOLD_OFF); end
        n_tests++; if (n_clr !== 1) begin n_fail++; $display("FAIL nom_clr_pulses: got %0d expected 1", n_clr); end
        n_tests++; if (t_idle !== t_clr + 3) begin n_fail++; $display("FAIL nom_rejoin: got %0d expected %0d", t_idle, t_clr + 3); end
        e = exp_q.pop_front();
        n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL nom_cnt: got %0d expected %0d", rst_cnt_o, e.cnt); end
        n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL nom_irq: got %b expected %b", irq_o, e.irq); end
        n_tests++; if (isolate_o !== 1'b0) begin n_fail++; $display("FAIL nom_iso_end: got %b expected 0", isolate_o); end
    endtask

    task automatic test_timeout();
        int t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle;
        bit to;
        exp_t e;
        wait_idle(10);
        iso_en = 1'b0;
        model_request(1'b1);
        run_seq(1'b0, t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL to_done: timed out"); end
        n_tests++; if (t_fall - t_iso !== ISO_TIMEOUT) begin n_fail++; $display("FAIL to_delay: got %0d expected %0d", t_fall - t_iso, ISO_TIMEOUT); end
        n_tests++; if (n_low !== RST_CYCLES) begin n_fail++; $display("FAIL to_rst_len: got %0d expected %0d", n_low, RST_CYCLES); end
        e = exp_q.pop_front();
        n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL to_cnt: got %0d expected %0d", rst_cnt_o, e.cnt); end
        n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL to_irq: got %b expected %b", irq_o, e.irq); end
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL to_irq_clr: got %b expected 0", irq_o); end
        iso_en = 1'b1;
    endtask

    task automatic test_irq_simul();
        @(negedge clk);
        irq_i = 1'b1; irq_clr_i = 1'b1;
        @(negedge clk);
        irq_i = 1'b0; irq_clr_i = 1'b1;
        n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set_prio: got %b expected 1", irq_o); end
        @(negedge clk);
        irq_clr_i = 1'b0;
        n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b expected 0", irq_o); end
    endtask

    task automatic test_escalation();
        int t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle;
        bit to;
        exp_t e;
        do_reset();
        for (int k = 0; k < MAX_RETRIES; k++) begin
            if (k > 0) wait_idle(10);
            model_request(1'b0);
            run_seq(1'b0, t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle, to);
            n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL esc_done%0d: timed out", k); end
            n_tests++; if (n_low !== RST_CYCLES) begin n_fail++; $display("FAIL esc_rst_len%0d: got %0d expected %0d", k, n_low, RST_CYCLES); end
            e = exp_q.pop_front();
            n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL esc_cnt%0d: got %0d expected %0d", k, rst_cnt_o, e.cnt); end
        end
        wait_idle(10);
        model_request(1'b0);
        @(negedge clk);
        rst_req_i = 1'b1;
        @(negedge clk);
        rst_req_i = 1'b0;
        e = exp_q.pop_front();
        n_tests++; if (fatal_o !== e.fatal) begin n_fail++; $display("FAIL esc_fatal: got %b expected %b", fatal_o, e.fatal); end
        n_tests++; if (slv_rst_no !== 1'b0) begin n_fail++; $display("FAIL esc_slv_rst_n: got %b expected 0", slv_rst_no); end
        n_tests++; if (isolate_o !== 1'b1) begin n_fail++; $display("FAIL esc_isolate: got %b expected 1", isolate_o); end
        n_tests++; if (irq_o !== e.irq) begin n_fail++; $display("FAIL esc_irq: got %b expected %b", irq_o, e.irq); end
        n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL esc_cnt_fatal: got %0d expected %0d", rst_cnt_o, e.cnt); end
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL esc_irq_sticky: got %b expected 1", irq_o); end
        n_tests++; if (fatal_o !== 1'b1) begin n_fail++; $display("FAIL esc_fatal_hold: got %b expected 1", fatal_o); end
    endtask

    task automatic test_quiet();
        int t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle;
        bit to;
        exp_t e;
        do_reset();
        for (int k = 0; k <= MAX_RETRIES; k++) begin
            if (k == MAX_RETRIES) wait_idle(QUIET);
            else if (k > 0) wait_idle(10);
            model_request(1'b0);
            run_seq(1'b0, t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle, to);
            n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL quiet_done%0d: timed out fatal=%b", k, fatal_o); end
            e = exp_q.pop_front();
            n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL quiet_cnt%0d: got %0d expected %0d", k, rst_cnt_o, e.cnt); end
        end
        n_tests++; if (fatal_o !== 1'b0) begin n_fail++; $display("FAIL quiet_fatal: got %b expected 0", fatal_o); end
        n_tests++; if (n_low !== RST_CYCLES) begin n_fail++; $display("FAIL quiet_rst_len: got %0d expected %0d", n_low, RST_CYCLES); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        model_request(1'b0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_req_i = 1'b1;
        @(negedge clk);
        rst_req_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!slv_rst_no) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach_reset: slv_rst_no never fell"); end
        repeat (4) @(negedge clk);
        n_tests++; if (slv_rst_no !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: got %b expected 0", slv_rst_no); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        m_cnt = 0; m_retry = 0;
        n_tests++; if (slv_rst_no !== 1'b1) begin n_fail++; $display("FAIL mid_slv_rst_n: got %b expected 1", slv_rst_no); end
        n_tests++; if (isolate_o !== 1'b0) begin n_fail++; $display("FAIL mid_isolate: got %b expected 0", isolate_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy_o); end
        n_tests++; if (rst_cnt_o !== '0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", rst_cnt_o); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle;
        bit to;
        bit done = 1'b0;
        exp_t e;
        model_request(1'b0);
        run_seq(1'b1, t_iso, t_fall, t_rise, n_low, t_clr, n_clr, t_idle, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_first: timed out"); end
        e = exp_q.pop_front();
        n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL b2b_cnt1: got %0d expected %0d", rst_cnt_o, e.cnt); end
        model_request(1'b0);
        @(negedge clk);
        rst_req_i = 1'b0;
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_reenter_busy: got %b expected 1", busy_o); end
        n_tests++; if (isolate_o !== 1'b1) begin n_fail++; $display("FAIL b2b_reenter_iso: got %b expected 1", isolate_o); end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_o) begin done = 1'b1; break; end
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second: timed out"); end
        e = exp_q.pop_front();
        n_tests++; if (rst_cnt_o !== CNT_W'(e.cnt)) begin n_fail++; $display("FAIL b2b_cnt2: got %0d expected %0d", rst_cnt_o, e.cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_irq_simul();
        test_escalation();
        test_quiet();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/slv_guard_rst_ctrl.md
Name: slv_guard_rst_ctrl

Overview:
- Recovery sequencer directly downstream of slv_guard_top; consumes its rst_req_o/irq_o.
- On a reset request it:
  - isolates the protected AXI subordinate through an external isolate stage;
  - holds the subordinate in reset;
  - pulses a clear to the guard;
  - rejoins the subordinate to the bus.
- Counts recoveries, escalates to a fatal lock-out after repeated back-to-back failures, and aggregates a sticky host interrupt.

Parameters:
- RstCycles, 16, cycles slv_rst_no is held low (>=1).
- IsoTimeout, 256, max cycles waiting for isolated_i before forcing reset anyway (>=1).
- HoldOffCycles, 8, cycles after reset release before guard clear and rejoin (>=1).
- QuietCycles, 1024, rst_req-free cycles in IDLE that reset the retry counter.
- MaxRetries, 3, recoveries allowed without a quiet period before FATAL.
- CntWidth, 32, width of the recovery event counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rst_req_i  in  1  reset request from guard (level, sampled)
- irq_i  in  1  guard interrupt (level)
- isolated_i  in  1  isolate stage: 1 = path drained and blocked, 0 = rejoined
- irq_clr_i  in  1  software clear of sticky irq_o
- isolate_o  out  1  request isolation of subordinate AXI path
- slv_rst_no  out  1  active-low reset to protected subordinate
- guard_clr_o  out  1  single-cycle pulse clearing guard budgets/state
- irq_o  out  1  sticky host interrupt
- busy_o  out  1  FSM not in IDLE
- fatal_o  out  1  retry limit exceeded, subordinate locked out
- rst_cnt_o  out  CntWidth  completed recoveries, saturating

Behaviour:
- Reset values (rst_i=1 at a clock edge): state IDLE; isolate_o=0, slv_rst_no=1, guard_clr_o=0, irq_o=0, busy_o=0, fatal_o=0, rst_cnt_o=0, retry and timer counters 0. rst_i mid-sequence aborts immediately to these values; the subordinate leaves reset on the cycle after rst_i is sampled high.
- All outputs are registered. Internal timer width is $clog2 of the largest of the cycle parameters, plus 1.
- IDLE:
  - rst_req_i=1 -> ISOLATE next cycle; isolate_o=1, timer cleared.
  - Otherwise quiet timer counts up; when it reaches QuietCycles the retry counter clears.
- ISOLATE:
  - isolated_i=1 -> RESET.
  - timer reaching IsoTimeout-1 -> RESET anyway and set irq_o.
- RESET:
  - slv_rst_no=0 for exactly RstCycles cycles, isolate_o stays 1, then -> RELEASE.
- RELEASE:
  - slv_rst_no=1; after HoldOffCycles, guard_clr_o pulses for 1 cycle, isolate_o drops to 0, -> REJOIN.
- REJOIN:
  - wait for isolated_i=0, then -> IDLE.
  - On that transition rst_cnt_o increments (saturates at all-ones), the retry counter increments, and the quiet timer clears.
  - rst_req_i during REJOIN is ignored; it is re-sampled in IDLE.
- Retry limit:
  - An IDLE->ISOLATE transition with retry counter == MaxRetries goes to FATAL instead.
  - FATAL: isolate_o=1, slv_rst_no=0, fatal_o=1, irq_o=1; left only by rst_i.
- irq_o set conditions: irq_i=1, isolation timeout, or entry to FATAL.
- irq_o clear: irq_clr_i=1 clears it, except in FATAL. Set has priority over a simultaneous clear.
- busy_o = (state != IDLE).
- rst_req_i held high continuously causes a back-to-back sequence: ISOLATE is re-entered one cycle after returning to IDLE.

Decomposition:
- Package slv_guard_pkg:
  - rst_ctrl_state_e (IDLE, ISOLATE, RESET, RELEASE, REJOIN, FATAL), 3 bits;
  - a shared CntWidth default constant.
- One sub-module, slv_guard_timer:
  - load/clear, enable, compare-to-limit terminal count;
  - instanced once and time-shared by ISOLATE, RESET and RELEASE;
  - the quiet timer is a second instance.

Test Plan:
- Nominal recovery:
  - Stimulus: RstCycles=16, HoldOffCycles=8; rst_req_i 1-cycle pulse; isolated_i rises 3 cycles after isolate_o and falls 2 cycles after isolate_o drops.
  - Response: isolate_o high 1 cycle after request; slv_rst_no low exactly 16 cycles; guard_clr_o single pulse 8 cycles after release; rst_cnt_o=1; irq_o=0; busy_o low in the end.
- Isolation timeout:
  - Stimulus: IsoTimeout=256, isolated_i tied 0.
  - Response: slv_rst_no falls 256 cycles after isolate_o rose; irq_o=1; irq_clr_i pulse -> irq_o=0 the next cycle.
- Retry escalation:
  - Stimulus: MaxRetries=3; four requests each issued 10 cycles after returning to IDLE (<QuietCycles).
  - Response: three full recoveries with rst_cnt_o=3; fourth request -> fatal_o=1, slv_rst_no=0, isolate_o=1; irq_clr_i does not clear irq_o.
- Quiet-period reset:
  - Stimulus: three recoveries, then 1024 idle cycles, then one more request.
  - Response: normal recovery, rst_cnt_o=4, fatal_o=0.
- Reset mid-sequence:
  - Stimulus: rst_i asserted during RESET state, cycle 5 of 16.
  - Response: slv_rst_no=1 and isolate_o=0 the next cycle; rst_cnt_o=0; state IDLE.
- Simultaneous events:
  - Stimulus: irq_i and irq_clr_i asserted in the same cycle.
  - Response: irq_o=1.
  - Stimulus: rst_req_i held high through a full sequence.
  - Response: ISOLATE re-entered exactly 1 cycle after IDLE.
